snitch_ssr_lsu_arbiter: RTL and testbench

- Shares one snitch_lsu_ssr port among NumReq SSR streamer lanes.
- Round-robin arbitrates the request (q) channel; a grant is locked until the LSU accepts it.
- Records grant order in two order queues, so write bursts (s) and read bursts (l) go to/from the owning lane in issue order.
- Sits between the SSR streamers and the LSU; all channels on both sides use the LSU request/response types.

---
 rtl/snitch_ssr_lsu_arb_pkg.sv | 50 +++++
 rtl/fifo_v3.sv | 86 ++++++++
 rtl/snitch_ssr_lsu_arbiter.sv | 155 +++++++++++++++
 tb/tb_snitch_ssr_lsu_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_ssr_lsu_arb_pkg.sv
// Shared types for the SSR-to-LSU arbiter.
// Provides the lane index width helper, a default lane index type and the
// LSU request/response structs used on both sides of the arbiter.
package snitch_ssr_lsu_arb_pkg;

  // Lane index width; a single-lane arbiter still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int unsigned DefaultNumReq = 3;
  localparam int unsigned IdxW          = idx_width(DefaultNumReq);

  typedef logic [IdxW-1:0] idx_t;

  // Request channel payload; len is the number of burst beats minus one.
  typedef struct packed {
    logic [31:0] addr;
    logic        q_write;
    logic [7:0]  len;
  } lsu_q_t;

  // Write data beat.
  typedef struct packed {
    logic [63:0] data;
    logic        s_last;
  } lsu_s_t;

  // Read data beat.
  typedef struct packed {
    logic [63:0] data;
    logic        l_last;
  } lsu_l_t;

  typedef struct packed {
    lsu_q_t q;
    logic   q_valid;
    lsu_s_t s;
    logic   s_valid;
    logic   l_ready;
  } lsu_req_t;

  typedef struct packed {
    lsu_l_t l;
    logic   q_ready;
    logic   s_ready;
    logic   l_valid;
  } lsu_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            drop all contents
//   testmode_i         unused, kept for interface compatibility
//   full_o, empty_o    occupancy flags
//   usage_o            current fill level (wraps to 0 when full at power-of-two depth)
//   data_i, push_i     write port
//   data_o, pop_i      read port (head element)
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  typedef logic [ADDR_DEPTH-1:0] ptr_t;
  typedef logic [ADDR_DEPTH:0]   cnt_t;

  ptr_t rd_q, rd_d, wr_q, wr_d;
  cnt_t cnt_q, cnt_d;
  dtype mem_q [DEPTH];

  assign full_o  = (cnt_q == cnt_t'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    data_o = mem_q[rd_q];
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i && !full_o) begin
        wr_d  = (wr_q == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(wr_q + 1'b1);
        cnt_d = cnt_t'(cnt_q + 1'b1);
      end
      if (pop_i && !empty_o) begin
        rd_d  = (rd_q == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(rd_q + 1'b1);
        cnt_d = cnt_t'(cnt_d - 1'b1);
      end
      // Fall-through: an empty FIFO passes data straight to the head.
      if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
        data_o = data_i;
        if (pop_i) begin
          rd_d  = rd_q;
          wr_d  = wr_q;
          cnt_d = cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !full_o && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/snitch_ssr_lsu_arbiter.sv
// Shares one LSU port among NumReq SSR streamer lanes.
// The q channel is round-robin arbitrated and locked until accepted; the
// grant order is recorded in a read order queue (ROQ) and a write order
// queue (WOQ) so that s beats and l beats follow the lane that issued them.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i / rsp_o  per-lane request / response
//   lsu_req_o      request towards the shared LSU
//   lsu_rsp_i      response from the shared LSU
module snitch_ssr_lsu_arbiter
  import snitch_ssr_lsu_arb_pkg::*;
#(
  parameter int unsigned NumReq               = 3,
  parameter int unsigned NumOutstandingLoads  = 4,
  parameter int unsigned NumOutstandingStores = 4,
  parameter type         lsu_req_t            = snitch_ssr_lsu_arb_pkg::lsu_req_t,
  parameter type         lsu_rsp_t            = snitch_ssr_lsu_arb_pkg::lsu_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  lsu_req_t req_i [NumReq-1:0],
  output lsu_rsp_t rsp_o [NumReq-1:0],
  output lsu_req_t lsu_req_o,
  input  lsu_rsp_t lsu_rsp_i
);

  localparam int unsigned LaneIdxW = idx_width(NumReq);
  localparam int unsigned RoqAddrW = (NumOutstandingLoads > 1) ? $clog2(NumOutstandingLoads) : 1;
  localparam int unsigned WoqAddrW = (NumOutstandingStores > 1) ? $clog2(NumOutstandingStores) : 1;

  typedef logic [LaneIdxW-1:0] lane_idx_t;
  typedef logic [LaneIdxW:0]   cand_t;

  lane_idx_t rr_q, lock_idx_q, grant, roq_head, woq_head;
  logic      lock_q, grant_valid, q_valid, q_hs, grant_write;
  logic      roq_full, roq_empty, woq_full, woq_empty;
  logic      roq_push, woq_push, roq_pop, woq_pop;
  logic [RoqAddrW-1:0] roq_usage;
  logic [WoqAddrW-1:0] woq_usage;
  logic [NumReq-1:0]   eligible;
  cand_t     cand;

  // A full order queue masks the lane; a same-cycle pop does not free it.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_i[i].q_valid && !(req_i[i].q.q_write ? woq_full : roq_full);
    end
  end

  // First eligible lane at or after the rr pointer; a pending grant wins outright.
  always_comb begin
    grant       = lock_idx_q;
    grant_valid = lock_q;
    cand        = '0;
    if (!lock_q) begin
      for (int off = 0; off < NumReq; off++) begin
        cand = cand_t'({1'b0, rr_q}) + cand_t'(off);
        if (cand >= cand_t'(NumReq)) cand = cand - cand_t'(NumReq);
        if (!grant_valid && eligible[cand[LaneIdxW-1:0]]) begin
          grant       = cand[LaneIdxW-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Reset forces the request side quiet even while lanes keep requesting.
  assign q_valid = rst_ni && grant_valid;
  assign q_hs    = q_valid && lsu_rsp_i.q_ready;

  always_comb begin
    lsu_req_o   = '0;
    grant_write = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_o[i]   = '0;
      rsp_o[i].l = lsu_rsp_i.l;
      if (lane_idx_t'(i) == grant) begin
        lsu_req_o.q       = req_i[i].q;
        grant_write       = req_i[i].q.q_write;
        rsp_o[i].q_ready  = q_valid && lsu_rsp_i.q_ready;
      end
      if (!woq_empty && (lane_idx_t'(i) == woq_head)) begin
        lsu_req_o.s       = req_i[i].s;
        lsu_req_o.s_valid = req_i[i].s_valid;
        rsp_o[i].s_ready  = lsu_rsp_i.s_ready;
      end
      if (!roq_empty && (lane_idx_t'(i) == roq_head)) begin
        rsp_o[i].l_valid  = lsu_rsp_i.l_valid;
        lsu_req_o.l_ready = req_i[i].l_ready;
      end
    end
    lsu_req_o.q_valid = q_valid;
  end

  assign roq_push = q_hs && !grant_write;
  assign woq_push = q_hs && grant_write;
  assign woq_pop  = lsu_req_o.s_valid && lsu_rsp_i.s_ready && lsu_req_o.s.s_last;
  assign roq_pop  = lsu_rsp_i.l_valid && lsu_req_o.l_ready && lsu_rsp_i.l.l_last;

  // The lock keeps q stable across LSU back-pressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= q_valid && !lsu_rsp_i.q_ready;
      if (q_valid && !lsu_rsp_i.q_ready) lock_idx_q <= grant;
      if (q_hs) rr_q <= (grant == lane_idx_t'(NumReq - 1)) ? '0 : lane_idx_t'(grant + 1'b1);
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (NumOutstandingLoads),
    .dtype        (lane_idx_t)
  ) i_roq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (roq_full),
    .empty_o    (roq_empty),
    .usage_o    (roq_usage),
    .data_i     (grant),
    .push_i     (roq_push),
    .data_o     (roq_head),
    .pop_i      (roq_pop)
  );

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (NumOutstandingStores),
    .dtype        (lane_idx_t)
  ) i_woq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (woq_full),
    .empty_o    (woq_empty),
    .usage_o    (woq_usage),
    .data_i     (grant),
    .push_i     (woq_push),
    .data_o     (woq_head),
    .pop_i      (woq_pop)
  );

  // A non-empty queue has a non-zero usage unless it is exactly full.
  assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> $stable(lsu_req_o.q));
  assert property (@(posedge clk_i) disable iff (!rst_ni) roq_pop |-> ((roq_usage != '0) || roq_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni) woq_pop |-> ((woq_usage != '0) || woq_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni) lsu_rsp_i.l_valid |-> !roq_empty);

endmodule

// File: tb/tb_snitch_ssr_lsu_arbiter.sv
// Directed bench for snitch_ssr_lsu_arbiter: a default instance (depth 4/4)
// and a second instance with a two-entry read order queue.
module tb_snitch_ssr_lsu_arbiter;
  import snitch_ssr_lsu_arb_pkg::*;

  logic     clk;
  logic     rst_ni;
  lsu_req_t req [2:0];
  lsu_rsp_t rsp [2:0];
  lsu_req_t lsu_req;
  lsu_rsp_t lsu_rsp;
  lsu_req_t b_req [2:0];
  lsu_rsp_t b_rsp [2:0];
  lsu_req_t b_lsu_req;
  lsu_rsp_t b_lsu_rsp;

  int compared;
  int mismatched;
  int beat0, beat2;

  snitch_ssr_lsu_arbiter #(
    .NumReq(3), .NumOutstandingLoads(4), .NumOutstandingStores(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .rsp_o(rsp),
    .lsu_req_o(lsu_req), .lsu_rsp_i(lsu_rsp)
  );

  snitch_ssr_lsu_arbiter #(
    .NumReq(3), .NumOutstandingLoads(2), .NumOutstandingStores(4)
  ) dut_small (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(b_req), .rsp_o(b_rsp),
    .lsu_req_o(b_lsu_req), .lsu_rsp_i(b_lsu_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    for (int i = 0; i < 3; i++) begin
      req[i]   = '0;
      b_req[i] = '0;
    end
    lsu_rsp   = '0;
    b_lsu_rsp = '0;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input int lane, input logic write, input logic [7:0] len);
    req[lane].q_valid   = 1'b1;
    req[lane].q.addr    = 32'h100 + 32'(lane * 16);
    req[lane].q.q_write = write;
    req[lane].q.len     = len;
  endtask

  // Lane store beats carry data lane*16+beat.
  task automatic drive_s;
    req[2].s_valid  = (beat2 <= 3);
    req[2].s.data   = 64'(32 + beat2);
    req[2].s.s_last = (beat2 == 3);
    req[0].s_valid  = (beat0 <= 1);
    req[0].s.data   = 64'(beat0);
    req[0].s.s_last = (beat0 == 1);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_ni = 1'b0;
    req[0].q_valid  = 1'b1;
    req[0].l_ready  = 1'b1;
    lsu_rsp.q_ready = 1'b1;
    lsu_rsp.s_ready = 1'b1;
    #3;
    compared++; if (lsu_req.q_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_q_valid: got %0b want 0", lsu_req.q_valid); end
    compared++; if (lsu_req.s_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_s_valid: got %0b want 0", lsu_req.s_valid); end
    compared++; if (lsu_req.l_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_l_ready: got %0b want 0", lsu_req.l_ready); end
    compared++; if (rsp[0].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_q_ready0: got %0b want 0", rsp[0].q_ready); end
    compared++; if (rsp[0].s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_s_ready0: got %0b want 0", rsp[0].s_ready); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_q(i, 1'b0, 8'd0);
      req[i].l_ready = 1'b1;
    end
    lsu_rsp.q_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      compared++; if (lsu_req.q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_q_valid%0d: got %0b want 1", g, lsu_req.q_valid); end
      compared++; if (lsu_req.q.addr !== 32'h100 + 32'(g * 16)) begin mismatched++; $display("[TB] FAIL rr_addr%0d: got %0h want %0h", g, lsu_req.q.addr, 32'h100 + 32'(g * 16)); end
      compared++; if (rsp[g].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_q_ready%0d: got %0b want 1", g, rsp[g].q_ready); end
      compared++; if (rsp[(g + 1) % 3].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_other_ready%0d: got %0b want 0", g, rsp[(g + 1) % 3].q_ready); end
      tick();
      req[g].q_valid = 1'b0;
    end
    @(negedge clk);
    compared++; if (lsu_req.q_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_idle: got %0b want 0", lsu_req.q_valid); end
    compared++; if (lsu_req.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_l_ready: got %0b want 1", lsu_req.l_ready); end
    // Drain the ROQ: one single-beat read per lane, returned in grant order.
    for (int g = 0; g < 3; g++) begin
      tick();
      lsu_rsp.l_valid  = 1'b1;
      lsu_rsp.l.data   = 64'hD0 + 64'(g);
      lsu_rsp.l.l_last = 1'b1;
      @(negedge clk);
      compared++; if (rsp[g].l_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL roq_head%0d: got %0b want 1", g, rsp[g].l_valid); end
      compared++; if (rsp[(g + 1) % 3].l_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL roq_other%0d: got %0b want 0", g, rsp[(g + 1) % 3].l_valid); end
      compared++; if (rsp[g].l.data !== 64'hD0 + 64'(g)) begin mismatched++; $display("[TB] FAIL roq_data%0d: got %0h want %0h", g, rsp[g].l.data, 64'hD0 + 64'(g)); end
    end
    tick();
    lsu_rsp.l_valid = 1'b0;
    lsu_rsp.q_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_q(i, 1'b0, 8'd0);
    @(negedge clk);
    compared++; if (lsu_req.q.addr !== 32'h100) begin mismatched++; $display("[TB] FAIL rr_wrap: got %0h want 100", lsu_req.q.addr); end
  endtask

  task automatic test_lock;
    do_reset();
    set_q(1, 1'b1, 8'd0);
    @(negedge clk);
    compared++; if (lsu_req.q.addr !== 32'h110) begin mismatched++; $display("[TB] FAIL lock_c1_addr: got %0h want 110", lsu_req.q.addr); end
    compared++; if (rsp[1].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_c1_ready: got %0b want 0", rsp[1].q_ready); end
    tick();
    set_q(0, 1'b0, 8'd0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      compared++; if (lsu_req.q.addr !== 32'h110) begin mismatched++; $display("[TB] FAIL lock_c%0d_addr: got %0h want 110", c, lsu_req.q.addr); end
      compared++; if (lsu_req.q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_c%0d_valid: got %0b want 1", c, lsu_req.q_valid); end
      tick();
    end
    lsu_rsp.q_ready = 1'b1;
    @(negedge clk);
    compared++; if (lsu_req.q.addr !== 32'h110) begin mismatched++; $display("[TB] FAIL lock_c4_addr: got %0h want 110", lsu_req.q.addr); end
    compared++; if (rsp[1].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_c4_ready1: got %0b want 1", rsp[1].q_ready); end
    compared++; if (rsp[0].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_c4_ready0: got %0b want 0", rsp[0].q_ready); end
    tick();
    req[1].q_valid = 1'b0;
    @(negedge clk);
    compared++; if (lsu_req.q.addr !== 32'h100) begin mismatched++; $display("[TB] FAIL lock_c5_addr: got %0h want 100", lsu_req.q.addr); end
    compared++; if (rsp[0].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_c5_ready0: got %0b want 1", rsp[0].q_ready); end
    tick();
    req[0].q_valid = 1'b0;
  endtask

  task automatic test_write_order;
    logic hs0, hs2;
    int   exp_lane, exp_beat;
    do_reset();
    lsu_rsp.q_ready = 1'b1;
    lsu_rsp.s_ready = 1'b1;
    beat0 = 0;
    beat2 = 0;
    set_q(2, 1'b1, 8'd3);
    drive_s();
    @(negedge clk);
    compared++; if (lsu_req.s_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_early_s_valid: got %0b want 0", lsu_req.s_valid); end
    compared++; if (rsp[2].s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_early_s_ready2: got %0b want 0", rsp[2].s_ready); end
    compared++; if (rsp[2].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_q_ready2: got %0b want 1", rsp[2].q_ready); end
    tick();
    req[2].q_valid = 1'b0;
    set_q(0, 1'b1, 8'd1);
    for (int k = 0; k < 6; k++) begin
      exp_lane = (k < 4) ? 2 : 0;
      exp_beat = (k < 4) ? k : k - 4;
      @(negedge clk);
      compared++; if (lsu_req.s_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_s_valid%0d: got %0b want 1", k, lsu_req.s_valid); end
      compared++; if (lsu_req.s.data !== 64'(exp_lane * 16 + exp_beat)) begin mismatched++; $display("[TB] FAIL wr_data%0d: got %0h want %0h", k, lsu_req.s.data, 64'(exp_lane * 16 + exp_beat)); end
      compared++; if (rsp[0].s_ready !== (exp_lane == 0)) begin mismatched++; $display("[TB] FAIL wr_s_ready0_%0d: got %0b want %0b", k, rsp[0].s_ready, exp_lane == 0); end
      compared++; if (rsp[2].s_ready !== (exp_lane == 2)) begin mismatched++; $display("[TB] FAIL wr_s_ready2_%0d: got %0b want %0b", k, rsp[2].s_ready, exp_lane == 2); end
      if (k == 0) begin
        compared++; if (rsp[0].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_q_ready0: got %0b want 1", rsp[0].q_ready); end
      end
      hs0 = rsp[0].s_ready && req[0].s_valid;
      hs2 = rsp[2].s_ready && req[2].s_valid;
      tick();
      if (k == 0) req[0].q_valid = 1'b0;
      if (hs0) beat0++;
      if (hs2) beat2++;
      drive_s();
    end
    @(negedge clk);
    compared++; if (lsu_req.s_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_done: got %0b want 0", lsu_req.s_valid); end
  endtask

  task automatic test_read_order;
    do_reset();
    lsu_rsp.q_ready = 1'b1;
    req[0].l_ready  = 1'b1;
    set_q(1, 1'b0, 8'd1);
    @(negedge clk);
    compared++; if (rsp[1].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_q_ready1: got %0b want 1", rsp[1].q_ready); end
    tick();
    req[1].q_valid = 1'b0;
    set_q(0, 1'b0, 8'd0);
    @(negedge clk);
    compared++; if (rsp[0].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_q_ready0: got %0b want 1", rsp[0].q_ready); end
    tick();
    req[0].q_valid   = 1'b0;
    lsu_rsp.l_valid  = 1'b1;
    lsu_rsp.l.data   = 64'hA0;
    lsu_rsp.l.l_last = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      compared++; if (lsu_req.l_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_stall_ready%0d: got %0b want 0", s, lsu_req.l_ready); end
      compared++; if (rsp[1].l_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_stall_valid1_%0d: got %0b want 1", s, rsp[1].l_valid); end
      compared++; if (rsp[0].l_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_stall_valid0_%0d: got %0b want 0", s, rsp[0].l_valid); end
      tick();
    end
    req[1].l_ready = 1'b1;
    @(negedge clk);
    compared++; if (lsu_req.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_b0_ready: got %0b want 1", lsu_req.l_ready); end
    compared++; if (rsp[1].l.data !== 64'hA0) begin mismatched++; $display("[TB] FAIL rd_b0_data: got %0h want a0", rsp[1].l.data); end
    tick();
    lsu_rsp.l.data   = 64'hA1;
    lsu_rsp.l.l_last = 1'b1;
    @(negedge clk);
    compared++; if (rsp[1].l_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_b1_valid1: got %0b want 1", rsp[1].l_valid); end
    compared++; if (rsp[0].l_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_b1_valid0: got %0b want 0", rsp[0].l_valid); end
    tick();
    lsu_rsp.l.data = 64'hB0;
    @(negedge clk);
    compared++; if (rsp[0].l_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_l0_valid0: got %0b want 1", rsp[0].l_valid); end
    compared++; if (rsp[1].l_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_l0_valid1: got %0b want 0", rsp[1].l_valid); end
    compared++; if (rsp[0].l.data !== 64'hB0) begin mismatched++; $display("[TB] FAIL rd_l0_data: got %0h want b0", rsp[0].l.data); end
    tick();
    lsu_rsp.l_valid = 1'b0;
    @(negedge clk);
    compared++; if (lsu_req.l_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_empty_ready: got %0b want 0", lsu_req.l_ready); end
  endtask

  task automatic test_roq_full;
    do_reset();
    b_lsu_rsp.q_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_req[i].q_valid = 1'b1;
      b_req[i].q.addr  = 32'h100 + 32'(i * 16);
      b_req[i].l_ready = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      compared++; if (b_lsu_req.q.addr !== 32'h100 + 32'(g * 16)) begin mismatched++; $display("[TB] FAIL full_addr%0d: got %0h want %0h", g, b_lsu_req.q.addr, 32'h100 + 32'(g * 16)); end
      tick();
      b_req[g].q_valid = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      compared++; if (b_lsu_req.q_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_masked%0d: got %0b want 0", c, b_lsu_req.q_valid); end
      compared++; if (b_rsp[2].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready2_%0d: got %0b want 0", c, b_rsp[2].q_ready); end
      tick();
    end
    b_lsu_rsp.l_valid  = 1'b1;
    b_lsu_rsp.l.l_last = 1'b1;
    @(negedge clk);
    compared++; if (b_rsp[0].l_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full_pop_valid: got %0b want 1", b_rsp[0].l_valid); end
    compared++; if (b_lsu_req.q_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_no_bypass: got %0b want 0", b_lsu_req.q_valid); end
    tick();
    b_lsu_rsp.l_valid = 1'b0;
    @(negedge clk);
    compared++; if (b_lsu_req.q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full_freed_valid: got %0b want 1", b_lsu_req.q_valid); end
    compared++; if (b_lsu_req.q.addr !== 32'h120) begin mismatched++; $display("[TB] FAIL full_freed_addr: got %0h want 120", b_lsu_req.q.addr); end
    compared++; if (b_rsp[2].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL full_freed_ready: got %0b want 1", b_rsp[2].q_ready); end
    tick();
    b_req[2].q_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    logic hs2;
    do_reset();
    lsu_rsp.q_ready = 1'b1;
    lsu_rsp.s_ready = 1'b1;
    beat0 = 2;
    beat2 = 0;
    set_q(2, 1'b1, 8'd3);
    drive_s();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hs2 = rsp[2].s_ready && req[2].s_valid;
      tick();
      if (c == 0) req[2].q_valid = 1'b0;
      if (hs2) beat2++;
      drive_s();
    end
    set_q(0, 1'b0, 8'd0);
    #1;
    compared++; if (lsu_req.s.data !== 64'(34)) begin mismatched++; $display("[TB] FAIL mid_beat2: got %0h want 22", lsu_req.s.data); end
    compared++; if (lsu_req.q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_q_valid: got %0b want 1", lsu_req.q_valid); end
    rst_ni = 1'b0;
    #1;
    compared++; if (lsu_req.q_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_q_valid: got %0b want 0", lsu_req.q_valid); end
    compared++; if (lsu_req.s_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_s_valid: got %0b want 0", lsu_req.s_valid); end
    compared++; if (rsp[2].s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_s_ready2: got %0b want 0", rsp[2].s_ready); end
    compared++; if (rsp[0].q_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_q_ready0: got %0b want 0", rsp[0].q_ready); end
    req[0].q_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    set_q(1, 1'b0, 8'd0);
    req[1].l_ready = 1'b1;
    @(negedge clk);
    compared++; if (lsu_req.s_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL post_rst_s_valid: got %0b want 0", lsu_req.s_valid); end
    compared++; if (rsp[2].s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL post_rst_s_ready2: got %0b want 0", rsp[2].s_ready); end
    compared++; if (lsu_req.q.addr !== 32'h110) begin mismatched++; $display("[TB] FAIL post_rst_addr: got %0h want 110", lsu_req.q.addr); end
    compared++; if (rsp[1].q_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_rst_q_ready1: got %0b want 1", rsp[1].q_ready); end
    tick();
    req[1].q_valid = 1'b0;
    @(negedge clk);
    compared++; if (lsu_req.l_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_rst_l_ready: got %0b want 1", lsu_req.l_ready); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    beat0      = 0;
    beat2      = 0;
    rst_ni     = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_write_order();
    test_read_order();
    test_roq_full();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
